// File: rtl/motor_speed_ramp.sv
// Multi-channel H-bridge speed controller: one shared PWM time base, and per channel a
// slew-limited duty ramp plus a reversal sequencer (decelerate, dead time, drive the new direction).
module motor_speed_ramp #(
    parameter int NUM_MOTORS  = 2,
    parameter int PWM_WIDTH   = 8,
    parameter int TICK_DIV    = 4,
    parameter int RAMP_PERIOD = 1024,
    parameter int RAMP_STEP   = 1,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            enable_in,
    input  logic [NUM_MOTORS*PWM_WIDTH-1:0] level_in,
    input  logic [NUM_MOTORS-1:0]           direction_in,
    output logic [2*NUM_MOTORS-1:0]         pwm_out,
    output logic [NUM_MOTORS*PWM_WIDTH-1:0] duty_out,
    output logic [NUM_MOTORS-1:0]           settled_out
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RAMP_W = (RAMP_PERIOD > 1) ? $clog2(RAMP_PERIOD) : 1;
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DECEL = 2'd1;
    localparam logic [1:0] ST_DEAD  = 2'd2;

    localparam logic [PRE_W-1:0]     PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [RAMP_W-1:0]    RAMP_LAST = RAMP_W'(RAMP_PERIOD - 1);
    localparam logic [DEAD_W-1:0]    DEAD_INIT = DEAD_W'(DEAD_CYCLES);
    localparam logic [PWM_WIDTH-1:0] STEP      = PWM_WIDTH'(RAMP_STEP);

    logic [PRE_W-1:0]     pre_cnt;
    logic [RAMP_W-1:0]    ramp_cnt;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic                 tick;
    logic                 strobe;

    assign tick   = (pre_cnt == PRE_LAST);
    assign strobe = (ramp_cnt == RAMP_LAST);

    // Shared time base: tick prescaler, PWM sawtooth and ramp strobe counter.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            ramp_cnt <= '0;
        end else begin
            pre_cnt  <= tick ? '0 : pre_cnt + 1'b1;
            ramp_cnt <= strobe ? '0 : ramp_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_ch
        logic [1:0]           state;
        logic [PWM_WIDTH-1:0] cur_duty;
        logic [PWM_WIDTH-1:0] level;
        logic [PWM_WIDTH-1:0] up_gap;
        logic [PWM_WIDTH-1:0] down_gap;
        logic [PWM_WIDTH-1:0] up_step;
        logic [PWM_WIDTH-1:0] down_step;
        logic [PWM_WIDTH-1:0] decel_step;
        logic [DEAD_W-1:0]    dead_cnt;
        logic                 cur_dir;
        logic                 dir_req;
        logic                 raw;
        logic                 fwd_q;
        logic                 rev_q;

        assign level      = level_in[i*PWM_WIDTH +: PWM_WIDTH];
        assign dir_req    = direction_in[i];
        assign raw        = (pwm_cnt < cur_duty);
        assign up_gap     = level - cur_duty;
        assign down_gap   = cur_duty - level;
        assign up_step    = (up_gap < STEP) ? up_gap : STEP;
        assign down_step  = (down_gap < STEP) ? down_gap : STEP;
        assign decel_step = (cur_duty < STEP) ? cur_duty : STEP;

        // Gating with enable_in here makes the legs drop on the very edge that sees the disable.
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                fwd_q <= 1'b0;
                rev_q <= 1'b0;
            end else begin
                fwd_q <= enable_in & raw & ~cur_dir & (state != ST_DEAD);
                rev_q <= enable_in & raw &  cur_dir & (state != ST_DEAD);
            end
        end

        // Ramp and reversal sequencer; a reversal always passes through zero duty and a dead time.
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                state    <= ST_RUN;
                cur_duty <= '0;
                cur_dir  <= 1'b0;
                dead_cnt <= '0;
            end else if (!enable_in) begin
                state    <= ST_DEAD;
                cur_duty <= '0;
                dead_cnt <= DEAD_INIT;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (dir_req != cur_dir) begin
                            state <= ST_DECEL;
                        end else if (strobe) begin
                            if (level > cur_duty) begin
                                cur_duty <= cur_duty + up_step;
                            end else begin
                                cur_duty <= cur_duty - down_step;
                            end
                        end
                    end
                    ST_DECEL: begin
                        if (dir_req == cur_dir) begin
                            state <= ST_RUN;
                        end else if (cur_duty == '0) begin
                            state    <= ST_DEAD;
                            dead_cnt <= DEAD_INIT;
                        end else if (strobe) begin
                            cur_duty <= cur_duty - decel_step;
                        end
                    end
                    ST_DEAD: begin
                        if (dead_cnt == '0) begin
                            cur_dir <= dir_req;
                            state   <= ST_RUN;
                        end else begin
                            dead_cnt <= dead_cnt - 1'b1;
                        end
                    end
                    default: state <= ST_RUN;
                endcase
            end
        end

        assign pwm_out[2*i]                          = fwd_q;
        assign pwm_out[2*i+1]                        = rev_q;
        assign duty_out[i*PWM_WIDTH +: PWM_WIDTH]    = cur_duty;
        assign settled_out[i] = (state == ST_RUN) & (cur_duty == level) & (cur_dir == dir_req);
    end

endmodule

// File: tb/tb_motor_speed_ramp.sv
// Bench for motor_speed_ramp: directed vector table, hand-built corner sequences and random
// stimulus, all compared every cycle against a behavioural model of the ramp/reversal rules.
module tb_motor_speed_ramp;

    localparam int NM          = 2;
    localparam int W           = 8;
    localparam int TICK_DIV    = 4;
    localparam int RAMP_PERIOD = 8;
    localparam int RAMP_STEP   = 16;
    localparam int DEAD_CYCLES = 5;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              enable_in;
    logic [NM*W-1:0]   level_in;
    logic [NM-1:0]     direction_in;
    logic [2*NM-1:0]   pwm_out;
    logic [NM*W-1:0]   duty_out;
    logic [NM-1:0]     settled_out;

    always #5 clk_in = ~clk_in;

    motor_speed_ramp #(
        .NUM_MOTORS (NM),
        .PWM_WIDTH  (W),
        .TICK_DIV   (TICK_DIV),
        .RAMP_PERIOD(RAMP_PERIOD),
        .RAMP_STEP  (RAMP_STEP),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .enable_in   (enable_in),
        .level_in    (level_in),
        .direction_in(direction_in),
        .pwm_out     (pwm_out),
        .duty_out    (duty_out),
        .settled_out (settled_out)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural reference: time base derived arithmetically from the cycle number since reset.
    typedef enum int {M_RUN, M_DECEL, M_DEAD} mstate_t;
    mstate_t         m_state [NM];
    int              m_duty  [NM];
    bit              m_dir   [NM];
    int              m_dead  [NM];
    logic [2*NM-1:0] m_pwm;
    int              k_cyc;

    typedef struct {
        bit       en;
        int       l0;
        int       l1;
        bit [1:0] dir;
        int       cycles;
        int       d0;
        int       d1;
        bit [1:0] settled;
    } vec_t;

    vec_t tbl[6];

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic checkValue(string name, int actual, int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        k_cyc = 0;
        m_pwm = '0;
        for (int i = 0; i < NM; i++) begin
            m_state[i] = M_RUN;
            m_duty[i]  = 0;
            m_dir[i]   = 1'b0;
            m_dead[i]  = 0;
        end
    endtask

    task automatic modelStep();
        bit strobe;
        int pcnt;
        int lvl;
        bit dreq;
        bit on;
        k_cyc++;
        strobe = (((k_cyc - 1) % RAMP_PERIOD) == RAMP_PERIOD - 1);
        pcnt   = ((k_cyc - 1) / TICK_DIV) % (1 << W);
        for (int i = 0; i < NM; i++) begin
            lvl  = int'(level_in[i*W +: W]);
            dreq = direction_in[i];
            on   = enable_in && (pcnt < m_duty[i]) && (m_state[i] != M_DEAD);
            m_pwm[2*i]   = on && !m_dir[i];
            m_pwm[2*i+1] = on && m_dir[i];
            if (!enable_in) begin
                m_duty[i]  = 0;
                m_state[i] = M_DEAD;
                m_dead[i]  = DEAD_CYCLES;
            end else begin
                case (m_state[i])
                    M_RUN: begin
                        if (dreq != m_dir[i]) m_state[i] = M_DECEL;
                        else if (strobe) begin
                            if (lvl > m_duty[i]) m_duty[i] += min2(RAMP_STEP, lvl - m_duty[i]);
                            else                 m_duty[i] -= min2(RAMP_STEP, m_duty[i] - lvl);
                        end
                    end
                    M_DECEL: begin
                        if (dreq == m_dir[i]) m_state[i] = M_RUN;
                        else if (m_duty[i] == 0) begin
                            m_state[i] = M_DEAD;
                            m_dead[i]  = DEAD_CYCLES;
                        end else if (strobe) m_duty[i] -= min2(RAMP_STEP, m_duty[i]);
                    end
                    default: begin
                        if (m_dead[i] == 0) begin
                            m_dir[i]   = dreq;
                            m_state[i] = M_RUN;
                        end else m_dead[i]--;
                    end
                endcase
            end
        end
    endtask

    task automatic checkOutput();
        bit exp_set;
        checkValue("pwm_out", int'(pwm_out), int'(m_pwm));
        for (int i = 0; i < NM; i++) begin
            exp_set = (m_state[i] == M_RUN) && (m_duty[i] == int'(level_in[i*W +: W]))
                      && (m_dir[i] == direction_in[i]);
            checkValue($sformatf("duty_out[%0d]", i), int'(duty_out[i*W +: W]), m_duty[i]);
            checkValue($sformatf("settled_out[%0d]", i), int'(settled_out[i]), int'(exp_set));
            checkValue($sformatf("legs exclusive[%0d]", i), int'(pwm_out[2*i] & pwm_out[2*i+1]), 0);
        end
    endtask

    task automatic applyStimulus(bit en, int l0, int l1, bit [1:0] dir);
        enable_in    = en;
        level_in     = {W'(l1), W'(l0)};
        direction_in = dir;
    endtask

    task automatic runCycles(int n);
        repeat (n) begin
            @(posedge clk_in);
            modelStep();
            @(negedge clk_in);
            checkOutput();
        end
    endtask

    task automatic doReset();
        rst_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        modelReset();
        checkOutput();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time limit reached before the test completed");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hi0;
        int hi1;
        bit found;
        int exp1[8];

        tbl[0] = '{1'b1, 128, 100, 2'b00,  80, 128, 100, 2'b11};
        tbl[1] = '{1'b1, 255,  90, 2'b00,  80, 255,  90, 2'b11};
        tbl[2] = '{1'b1,  64,  90, 2'b01, 250,  64,  90, 2'b11};
        tbl[3] = '{1'b0,  64,  90, 2'b01,   3,   0,   0, 2'b00};
        tbl[4] = '{1'b1,   0,   0, 2'b00,  20,   0,   0, 2'b11};
        tbl[5] = '{1'b1, 200,  50, 2'b10, 200, 200,  50, 2'b11};
        exp1 = '{16, 32, 48, 64, 80, 96, 100, 100};

        applyStimulus(1'b1, 0, 0, 2'b00);
        modelReset();
        doReset();

        for (int j = 0; j < 6; j++) begin
            applyStimulus(tbl[j].en, tbl[j].l0, tbl[j].l1, tbl[j].dir);
            runCycles(tbl[j].cycles);
            checkValue($sformatf("tbl[%0d] duty0", j), int'(duty_out[7:0]), tbl[j].d0);
            checkValue($sformatf("tbl[%0d] duty1", j), int'(duty_out[15:8]), tbl[j].d1);
            checkValue($sformatf("tbl[%0d] settled", j), int'(settled_out), int'(tbl[j].settled));
        end

        // Asynchronous reset while channel 0 is mid-high, between clock edges.
        found = 1'b0;
        for (int c = 0; c < 1100 && !found; c++) begin
            runCycles(1);
            found = pwm_out[0];
        end
        checkValue("pwm0 high before reset", int'(found), 1);
        #2 rst_in = 1'b1;
        #1;
        checkValue("async reset pwm_out", int'(pwm_out), 0);
        checkValue("async reset duty_out", int'(duty_out), 0);

        // Ramp up on both channels, non-multiple target on ch1, then PWM high-time windows.
        applyStimulus(1'b1, 128, 100, 2'b00);
        doReset();
        for (int j = 1; j <= 8; j++) begin
            runCycles(8);
            checkValue($sformatf("ramp duty0 step %0d", j), int'(duty_out[7:0]), 16 * j);
            checkValue($sformatf("ramp duty1 step %0d", j), int'(duty_out[15:8]), exp1[j-1]);
        end
        checkValue("ramp settled", int'(settled_out), 3);
        applyStimulus(1'b1, 128, 90, 2'b00);
        runCycles(8);
        checkValue("lowered duty1", int'(duty_out[15:8]), 90);
        hi0 = 0;
        hi1 = 0;
        for (int c = 0; c < 1024; c++) begin
            runCycles(1);
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);
        end
        checkValue("duty128 high clk", hi0, 512);
        checkValue("duty128 rev leg clk", hi1, 0);
        applyStimulus(1'b1, 255, 90, 2'b00);
        runCycles(80);
        hi0 = 0;
        for (int c = 0; c < 1024; c++) begin
            runCycles(1);
            hi0 += int'(pwm_out[0]);
        end
        checkValue("duty255 high clk", hi0, 1020);

        // Reversal of ch0 from 64: decel, dead time with both legs low, ramp in reverse.
        applyStimulus(1'b1, 64, 0, 2'b00);
        doReset();
        runCycles(32);
        checkValue("rev start duty0", int'(duty_out[7:0]), 64);
        applyStimulus(1'b1, 64, 0, 2'b01);
        for (int j = 1; j <= 4; j++) begin
            runCycles(8);
            checkValue($sformatf("decel step %0d", j), int'(duty_out[7:0]), 64 - 16 * j);
        end
        for (int c = 0; c < 7; c++) begin
            runCycles(1);
            checkValue($sformatf("dead legs %0d", c), int'(pwm_out[1:0]), 0);
            checkValue($sformatf("dead unsettled %0d", c), int'(settled_out[0]), 0);
        end
        runCycles(1);
        checkValue("rev ramp 16", int'(duty_out[7:0]), 16);
        for (int j = 2; j <= 4; j++) begin
            runCycles(8);
            checkValue($sformatf("rev ramp %0d", 16 * j), int'(duty_out[7:0]), 16 * j);
        end
        checkValue("rev settled", int'(settled_out[0]), 1);

        // Aborted reversal: direction restored while decelerating at 32.
        applyStimulus(1'b1, 64, 0, 2'b00);
        runCycles(8);
        checkValue("abort decel 48", int'(duty_out[7:0]), 48);
        runCycles(8);
        checkValue("abort decel 32", int'(duty_out[7:0]), 32);
        applyStimulus(1'b1, 64, 0, 2'b01);
        for (int c = 0; c < 16; c++) begin
            runCycles(1);
            checkValue($sformatf("abort no dead %0d", c), int'(duty_out[7:0] == 8'd0), 0);
            if (c == 7) checkValue("abort ramp 48", int'(duty_out[7:0]), 48);
        end
        checkValue("abort ramp 64", int'(duty_out[7:0]), 64);
        checkValue("abort settled", int'(settled_out[0]), 1);

        // Disable while running, then re-enable: dead time, then ramp from zero.
        applyStimulus(1'b0, 64, 0, 2'b01);
        runCycles(1);
        checkValue("disable pwm_out", int'(pwm_out), 0);
        checkValue("disable duty_out", int'(duty_out), 0);
        runCycles(2);
        applyStimulus(1'b1, 64, 0, 2'b01);
        for (int c = 1; c <= 12; c++) begin
            runCycles(1);
            checkValue($sformatf("reenable hold %0d", c), int'(duty_out[7:0]), 0);
        end
        runCycles(1);
        checkValue("reenable first step", int'(duty_out[7:0]), 16);

        // Randomized traffic against the reference model.
        for (int seg = 0; seg < 200; seg++) begin
            int l0;
            int l1;
            bit [1:0] d;
            l0 = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
            l1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            d  = direction_in;
            if ($urandom_range(0, 3) == 0) d = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 15) != 0), l0, l1, d);
            runCycles(int'($urandom_range(1, 40)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
